// File: rtl/inv_mix_columns_seq.sv
// AES InvMixColumns engine: accepts one 128-bit state, transforms one column per
// clock through a single shared GF(2^8) column multiplier, then holds the result.
module inv_mix_columns_seq #(
    parameter int word_size  = 8,
    parameter int array_size = 16
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [word_size*array_size-1:0] state,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [word_size*array_size-1:0] state_out,
    output logic                            busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } fsm_t;

    fsm_t        fsm;
    fsm_t        fsm_next;
    logic [1:0]  col;
    logic [127:0] src_reg;
    logic [127:0] work_reg;
    logic [31:0] col_in;
    logic [31:0] col_out;
    logic        accept;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // k selects which of b, 2b, 4b, 8b are summed; k is always a constant here
    function automatic logic [7:0] gf_mul(input logic [7:0] b, input logic [3:0] k);
        logic [7:0] x2;
        logic [7:0] x4;
        logic [7:0] x8;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return (k[3] ? x8 : 8'h00) ^ (k[2] ? x4 : 8'h00) ^
               (k[1] ? x2 : 8'h00) ^ (k[0] ? b  : 8'h00);
    endfunction

    function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
        logic [7:0] s0;
        logic [7:0] s1;
        logic [7:0] s2;
        logic [7:0] s3;
        s0 = c[31:24];
        s1 = c[23:16];
        s2 = c[15:8];
        s3 = c[7:0];
        return {gf_mul(s0, 4'he) ^ gf_mul(s1, 4'hb) ^ gf_mul(s2, 4'hd) ^ gf_mul(s3, 4'h9),
                gf_mul(s0, 4'h9) ^ gf_mul(s1, 4'he) ^ gf_mul(s2, 4'hb) ^ gf_mul(s3, 4'hd),
                gf_mul(s0, 4'hd) ^ gf_mul(s1, 4'h9) ^ gf_mul(s2, 4'he) ^ gf_mul(s3, 4'hb),
                gf_mul(s0, 4'hb) ^ gf_mul(s1, 4'hd) ^ gf_mul(s2, 4'h9) ^ gf_mul(s3, 4'he)};
    endfunction

    assign accept = in_valid && in_ready;

    always_comb begin
        case (col)
            2'd0:    col_in = src_reg[127:96];
            2'd1:    col_in = src_reg[95:64];
            2'd2:    col_in = src_reg[63:32];
            default: col_in = src_reg[31:0];
        endcase
    end

    assign col_out = inv_mix_col(col_in);

    always_ff @(posedge clk) begin
        if (reset) begin
            fsm <= IDLE;
        end else begin
            fsm <= fsm_next;
        end
    end

    always_comb begin
        fsm_next = fsm;
        case (fsm)
            IDLE:    if (in_valid) fsm_next = CALC;
            CALC:    if (col == 2'd3) fsm_next = DONE;
            DONE:    if (out_ready) fsm_next = IDLE;
            default: fsm_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (fsm == IDLE) && !reset;
        out_valid = (fsm == DONE);
        busy      = (fsm != IDLE);
    end

    // Column 3 bypasses work_reg so the full result lands on the edge entering DONE
    always_ff @(posedge clk) begin
        if (reset) begin
            col       <= 2'd0;
            src_reg   <= '0;
            work_reg  <= '0;
            state_out <= '0;
        end else if (accept) begin
            src_reg <= state;
            col     <= 2'd0;
        end else if (fsm == CALC) begin
            case (col)
                2'd0:    work_reg[127:96] <= col_out;
                2'd1:    work_reg[95:64]  <= col_out;
                2'd2:    work_reg[63:32]  <= col_out;
                default: work_reg[31:0]   <= col_out;
            endcase
            col <= col + 2'd1;
            if (col == 2'd3) begin
                state_out <= {work_reg[127:32], col_out};
            end
        end
    end

endmodule
